calc_seq_ctrl: RTL and testbench

Parametrised controller for the keypad calculator, successor to the fixed single-digit calculator FSM. It accepts multi-digit decimal operands from the decoded keypad, one of four operators, and Enter. It computes the result internally and writes operand A, operand B and the result into consecutive register-file entries, with a wrapping write pointer. A sweep mode replays the stored entries on the display at a programmable rate.

---
 rtl/calc_seq_ctrl_pkg.sv | 58 +++++
 rtl/calc_seq_ctrl_if.sv | 35 +++
 rtl/calc_seq_ctrl_digit_acc.sv | 48 ++++
 rtl/calc_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_seq_ctrl_pkg.sv
// pkg_calc: shared definitions for the keypad calculator controller.
//   - key code constants for the decoded keypad (0-9 are digits)
//   - calc_state_t : controller state, its encoding drives the RGB indicator
//   - calc_op_t    : latched arithmetic/logic operator
//   - small helpers for key classification and the operand-width check
package pkg_calc;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_AND = 4'hC;
    localparam logic [3:0] KEY_OR  = 4'hD;
    localparam logic [3:0] KEY_ENT = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        EXEC    = 3'd2,
        WR_A    = 3'd3,
        WR_B    = 3'd4,
        WR_R    = 3'd5,
        SWEEP   = 3'd6
    } calc_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } calc_op_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_oper(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_OR);
    endfunction

    function automatic calc_op_t key_to_op(input logic [3:0] k);
        case (k)
            KEY_SUB: return OP_SUB;
            KEY_AND: return OP_AND;
            KEY_OR:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if: keypad, register-file and display signals of the
// calculator controller.
//   master : keypad / register file / display side (drives keys, rdata)
//   slave  : the controller (drives write bus, read address, display, status)
interface calc_seq_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              key_valid_i;
    logic [3:0]        key_code_i;
    logic              mode_sweep_i;
    logic              we_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;
    logic [ADDR_W-1:0] raddr_o;
    logic [DATA_W-1:0] rdata_i;
    logic [DATA_W-1:0] display_o;
    logic              display_en_o;
    logic              err_o;
    logic              carry_o;
    logic [2:0]        state_o;

    modport master (
        output key_valid_i, key_code_i, mode_sweep_i, rdata_i,
        input  we_o, waddr_o, wdata_o, raddr_o, display_o, display_en_o,
               err_o, carry_o, state_o
    );

    modport slave (
        input  key_valid_i, key_code_i, mode_sweep_i, rdata_i,
        output we_o, waddr_o, wdata_o, raddr_o, display_o, display_en_o,
               err_o, carry_o, state_o
    );

endinterface

// File: rtl/calc_seq_ctrl_digit_acc.sv
// calc_digit_acc: decimal operand accumulator.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : clear value and digit count (wins over load_i)
//   load_i         : shift in digit_i (acc*10 + digit), ignored when full
//   digit_i        : decimal digit 0-9
//   acc_o          : accumulated value
//   count_o        : digits entered so far
//   full_o         : DIGITS digits already entered
module calc_digit_acc #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         clr_i,
    input  logic                         load_i,
    input  logic [3:0]                   digit_i,
    output logic [DATA_W-1:0]            acc_o,
    output logic [$clog2(DIGITS+1)-1:0]  count_o,
    output logic                         full_o
);
    localparam int CNT_W = $clog2(DIGITS + 1);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_x10;
    logic [CNT_W-1:0]  count_q;

    // x10 built from shifts; never overflows because load is refused when full
    assign acc_x10 = (acc_q << 3) + (acc_q << 1);
    assign full_o  = (count_q == CNT_W'(DIGITS));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q   <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            acc_q   <= '0;
            count_q <= '0;
        end else if (load_i && !full_o) begin
            acc_q   <= acc_x10 + DATA_W'(digit_i);
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign acc_o   = acc_q;
    assign count_o = count_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: keypad calculator controller.
//   clk_i   : system clock (10 MHz)
//   rst_n_i : asynchronous active-low reset
//   bus     : calc_seq_ctrl_if.slave
//             key_valid_i/key_code_i  decoded key pulses
//             mode_sweep_i            level request for sweep replay
//             we_o/waddr_o/wdata_o    register-file write (A, B, result)
//             raddr_o/rdata_i         register-file read for sweep
//             display_o/display_en_o  value to show
//             err_o                   one-cycle pulse per rejected key
//             carry_o                 carry/borrow of the last operation
//             state_o                 state encoding for the RGB indicator
// Holds the key FSM, ALU, write pointer/fill level and sweep timer; operand
// digits are accumulated in calc_digit_acc.
module calc_seq_ctrl
    import pkg_calc::*;
#(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 5,
    parameter int SWEEP_TICKS = 10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    calc_seq_ctrl_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int FILL_W = ADDR_W + 1;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int TICK_W = (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;

    if (pow10(DIGITS) - 1 >= (64'd1 << DATA_W)) begin : g_width_check
        $error("calc_seq_ctrl: DATA_W cannot hold DIGITS decimal digits");
    end

    calc_state_t       state_q, state_d;

    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_full;
    logic              acc_clr, acc_load;
    logic              count_zero;

    logic              k_digit, k_oper, k_ent, k_clr;
    logic              latch_a, latch_b, clr_op_a, err_d;

    logic [DATA_W-1:0] op_a_q, op_b_q, result_q;
    calc_op_t          op_q;
    logic              carry_q, err_q;
    logic [DATA_W:0]   alu_ext;

    logic [ADDR_W-1:0] ptr_q, raddr_q;
    logic [FILL_W-1:0] fill_q;
    logic [TICK_W-1:0] tick_q;
    logic              we;

    calc_digit_acc #(
        .DIGITS (DIGITS),
        .DATA_W (DATA_W)
    ) u_acc (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (acc_clr),
        .load_i  (acc_load),
        .digit_i (bus.key_code_i),
        .acc_o   (acc),
        .count_o (acc_count),
        .full_o  (acc_full)
    );

    assign count_zero = (acc_count == '0);
    assign k_digit    = bus.key_valid_i && is_digit(bus.key_code_i);
    assign k_oper     = bus.key_valid_i && is_oper(bus.key_code_i);
    assign k_ent      = bus.key_valid_i && (bus.key_code_i == KEY_ENT);
    assign k_clr      = bus.key_valid_i && (bus.key_code_i == KEY_CLR);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ENTRY_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_clr  = 1'b0;
        acc_load = 1'b0;
        latch_a  = 1'b0;
        latch_b  = 1'b0;
        clr_op_a = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ENTRY_A: begin
                // sweep request takes priority; a key in the same cycle is lost
                if (count_zero && bus.mode_sweep_i) begin
                    state_d = SWEEP;
                end else if (k_clr) begin
                    acc_clr  = 1'b1;
                    clr_op_a = 1'b1;
                end else if (k_digit) begin
                    if (acc_full) err_d = 1'b1;
                    else          acc_load = 1'b1;
                end else if (k_oper) begin
                    if (!count_zero) begin
                        latch_a = 1'b1;
                        acc_clr = 1'b1;
                        state_d = ENTRY_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (k_ent) begin
                    err_d = 1'b1;
                end
            end
            ENTRY_B: begin
                if (k_clr) begin
                    acc_clr  = 1'b1;
                    clr_op_a = 1'b1;
                    state_d  = ENTRY_A;
                end else if (k_digit) begin
                    if (acc_full) err_d = 1'b1;
                    else          acc_load = 1'b1;
                end else if (k_oper) begin
                    err_d = 1'b1;
                end else if (k_ent) begin
                    if (!count_zero) begin
                        latch_b = 1'b1;
                        acc_clr = 1'b1;
                        state_d = EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXEC:    state_d = WR_A;
            WR_A:    state_d = WR_B;
            WR_B:    state_d = WR_R;
            WR_R:    state_d = ENTRY_A;
            SWEEP: begin
                if (!bus.mode_sweep_i) state_d = ENTRY_A;
            end
            default: state_d = ENTRY_A;
        endcase
    end

    // one extra bit carries the add carry / sub borrow
    always_comb begin
        alu_ext = '0;
        case (op_q)
            OP_ADD:  alu_ext = {1'b0, op_a_q} + {1'b0, op_b_q};
            OP_SUB:  alu_ext = {1'b0, op_a_q} - {1'b0, op_b_q};
            OP_AND:  alu_ext = {1'b0, op_a_q & op_b_q};
            OP_OR:   alu_ext = {1'b0, op_a_q | op_b_q};
            default: alu_ext = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            if (latch_a) begin
                op_a_q <= acc;
                op_q   <= key_to_op(bus.key_code_i);
            end else if (clr_op_a) begin
                op_a_q <= '0;
            end
            if (latch_b) op_b_q <= acc;
            if (state_q == EXEC) begin
                result_q <= alu_ext[DATA_W-1:0];
                carry_q  <= alu_ext[DATA_W];
            end
        end
    end

    assign we = (state_q == WR_A) || (state_q == WR_B) || (state_q == WR_R);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q  <= '0;
            fill_q <= '0;
        end else if (we) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (fill_q != FILL_W'(DEPTH)) fill_q <= fill_q + FILL_W'(1);
        end
    end

    // Timer and read address restart whenever SWEEP is entered or left.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            raddr_q <= '0;
            tick_q  <= '0;
        end else if (state_q != SWEEP || state_d != SWEEP) begin
            raddr_q <= '0;
            tick_q  <= '0;
        end else if (tick_q == TICK_W'(SWEEP_TICKS - 1)) begin
            tick_q <= '0;
            if (fill_q == '0 || FILL_W'(raddr_q) == fill_q - FILL_W'(1))
                raddr_q <= '0;
            else
                raddr_q <= raddr_q + ADDR_W'(1);
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    always_comb begin
        bus.wdata_o   = '0;
        bus.display_o = acc;
        case (state_q)
            EXEC:    bus.display_o = alu_ext[DATA_W-1:0];
            WR_A: begin
                bus.wdata_o   = op_a_q;
                bus.display_o = result_q;
            end
            WR_B: begin
                bus.wdata_o   = op_b_q;
                bus.display_o = result_q;
            end
            WR_R: begin
                bus.wdata_o   = result_q;
                bus.display_o = result_q;
            end
            SWEEP:   bus.display_o = bus.rdata_i;
            default: bus.display_o = acc;
        endcase
    end

    assign bus.we_o         = we;
    assign bus.waddr_o      = ptr_q;
    assign bus.raddr_o      = raddr_q;
    assign bus.display_en_o = 1'b1;
    assign bus.err_o        = err_q;
    assign bus.carry_o      = carry_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed bench for calc_seq_ctrl. Two instances see the
// same key stream: dut_m (32 entries) and dut_s (4 entries, pointer wrap).
module tb_calc_seq_ctrl;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_AND = 4'hC;
    localparam logic [3:0] K_OR  = 4'hD;
    localparam logic [3:0] K_ENT = 4'hE;
    localparam logic [3:0] K_CLR = 4'hF;

    localparam logic [2:0] S_ENTRY_A = 3'd0;
    localparam logic [2:0] S_ENTRY_B = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_SWEEP   = 3'd6;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       mode_sweep;

    int n_pass  = 0;
    int n_total = 0;
    int ptr_m   = 0;
    int ptr_s   = 0;

    logic [15:0] rf_m [32];

    calc_seq_ctrl_if #(.DATA_W(16), .ADDR_W(5)) bus_m ();
    calc_seq_ctrl_if #(.DATA_W(16), .ADDR_W(2)) bus_s ();

    assign bus_m.key_valid_i  = key_valid;
    assign bus_m.key_code_i   = key_code;
    assign bus_m.mode_sweep_i = mode_sweep;
    assign bus_m.rdata_i      = rf_m[bus_m.raddr_o];
    assign bus_s.key_valid_i  = key_valid;
    assign bus_s.key_code_i   = key_code;
    assign bus_s.mode_sweep_i = mode_sweep;
    assign bus_s.rdata_i      = 16'h0000;

    calc_seq_ctrl #(.DIGITS(4), .DATA_W(16), .ADDR_W(5), .SWEEP_TICKS(4)) dut_m (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_m)
    );

    calc_seq_ctrl #(.DIGITS(4), .DATA_W(16), .ADDR_W(2), .SWEEP_TICKS(4)) dut_s (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_s)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (bus_m.we_o) rf_m[bus_m.waddr_o] <= bus_m.wdata_o;
    end

    typedef struct {
        logic [3:0]  key;
        logic [15:0] disp;
        logic        err;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic press_num(input int v);
        logic [3:0] digs [10];
        int n;
        int x;
        n = 0;
        x = v;
        do begin
            digs[n] = 4'(x % 10);
            x = x / 10;
            n++;
        end while (x > 0);
        for (int i = n - 1; i >= 0; i--) press(digs[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        ptr_s = 0;
    endtask

    task automatic run_op(input int a, input logic [3:0] opk, input int b,
                          input logic [15:0] exp_r, input logic exp_c);
        logic [15:0] exp_w;
        press_num(a);
        press(opk);
        press_num(b);
        press(K_ENT);
        chk("exec_state", bus_m.state_o, S_EXEC);
        chk("exec_display", bus_m.display_o, exp_r);
        chk("exec_no_we", bus_m.we_o, 0);
        for (int w = 0; w < 3; w++) begin
            @(posedge clk);
            #1;
            exp_w = (w == 0) ? 16'(a) : (w == 1) ? 16'(b) : exp_r;
            chk("wr_we_m", bus_m.we_o, 1);
            chk("wr_addr_m", bus_m.waddr_o, ptr_m);
            chk("wr_data_m", bus_m.wdata_o, exp_w);
            chk("wr_we_s", bus_s.we_o, 1);
            chk("wr_addr_s", bus_s.waddr_o, ptr_s);
            chk("wr_data_s", bus_s.wdata_o, exp_w);
            ptr_m = (ptr_m + 1) % 32;
            ptr_s = (ptr_s + 1) % 4;
        end
        chk("carry_m", bus_m.carry_o, exp_c);
        chk("carry_s", bus_s.carry_o, exp_c);
        @(posedge clk);
        #1;
        chk("post_wr_state", bus_m.state_o, S_ENTRY_A);
        chk("post_wr_we", bus_m.we_o, 0);
        chk("post_wr_display", bus_m.display_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_rf [6];
        int idx;

        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        mode_sweep = 1'b0;

        vecs[0]  = '{4'd1,  16'd1,    1'b0, S_ENTRY_A};
        vecs[1]  = '{4'd2,  16'd12,   1'b0, S_ENTRY_A};
        vecs[2]  = '{4'd3,  16'd123,  1'b0, S_ENTRY_A};
        vecs[3]  = '{4'd4,  16'd1234, 1'b0, S_ENTRY_A};
        vecs[4]  = '{4'd5,  16'd1234, 1'b1, S_ENTRY_A};
        vecs[5]  = '{K_ENT, 16'd1234, 1'b1, S_ENTRY_A};
        vecs[6]  = '{K_ADD, 16'd0,    1'b0, S_ENTRY_B};
        vecs[7]  = '{K_SUB, 16'd0,    1'b1, S_ENTRY_B};
        vecs[8]  = '{K_ENT, 16'd0,    1'b1, S_ENTRY_B};
        vecs[9]  = '{4'd9,  16'd9,    1'b0, S_ENTRY_B};
        vecs[10] = '{K_CLR, 16'd0,    1'b0, S_ENTRY_A};
        vecs[11] = '{K_ADD, 16'd0,    1'b1, S_ENTRY_A};
        vecs[12] = '{K_ENT, 16'd0,    1'b1, S_ENTRY_A};
        vecs[13] = '{4'd0,  16'd0,    1'b0, S_ENTRY_A};
        vecs[14] = '{K_SUB, 16'd0,    1'b0, S_ENTRY_B};
        vecs[15] = '{K_CLR, 16'd0,    1'b0, S_ENTRY_A};

        exp_rf[0] = 16'd5;
        exp_rf[1] = 16'd7;
        exp_rf[2] = 16'hFFFE;
        exp_rf[3] = 16'd9;
        exp_rf[4] = 16'd12;
        exp_rf[5] = 16'd8;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus_m.state_o, S_ENTRY_A);
        chk("rst_display", bus_m.display_o, 0);
        chk("rst_display_en", bus_m.display_en_o, 1);
        chk("rst_we", bus_m.we_o, 0);
        chk("rst_err", bus_m.err_o, 0);
        chk("rst_carry", bus_m.carry_o, 0);
        chk("rst_waddr", bus_m.waddr_o, 0);
        chk("rst_raddr", bus_m.raddr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // key handling vectors: digit limit, rejected operators/enter, clear
        for (int i = 0; i < 16; i++) begin
            press(vecs[i].key);
            chk($sformatf("vec%0d_display", i), bus_m.display_o, vecs[i].disp);
            chk($sformatf("vec%0d_err", i), bus_m.err_o, vecs[i].err);
            chk($sformatf("vec%0d_state", i), bus_m.state_o, vecs[i].st);
            chk($sformatf("vec%0d_no_we", i), bus_m.we_o, 0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_err_cleared", i), bus_m.err_o, 0);
        end

        run_op(12, K_ADD, 34, 16'd46, 1'b0);

        do_reset();
        run_op(5, K_SUB, 7, 16'hFFFE, 1'b1);
        run_op(9, K_AND, 12, 16'd8, 1'b0);
        run_op(5, K_OR, 10, 16'd15, 1'b0);
        // fourth operation on the 4-entry instance lands at 1, 2, 3
        chk("wrap_ptr_before", ptr_s, 1);
        run_op(1234, K_ADD, 4321, 16'd5555, 1'b0);
        chk("wrap_ptr_after", bus_s.waddr_o, 0);

        // sweep over six stored entries (small instance saturates at four)
        do_reset();
        run_op(5, K_SUB, 7, 16'hFFFE, 1'b1);
        run_op(9, K_AND, 12, 16'd8, 1'b0);
        @(negedge clk);
        mode_sweep = 1'b1;
        key_valid  = 1'b1;
        key_code   = 4'd3;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        chk("sweep_enter_m", bus_m.state_o, S_SWEEP);
        chk("sweep_enter_s", bus_s.state_o, S_SWEEP);
        for (int k = 0; k < 28; k++) begin
            if (k == 9) begin
                press(4'd7);
            end else if (k > 0) begin
                @(posedge clk);
                #1;
            end
            idx = (k / 4) % 6;
            chk($sformatf("sweep%0d_raddr_m", k), bus_m.raddr_o, idx);
            chk($sformatf("sweep%0d_display_m", k), bus_m.display_o, exp_rf[idx]);
            chk($sformatf("sweep%0d_raddr_s", k), bus_s.raddr_o, (k / 4) % 4);
        end
        chk("sweep_still_m", bus_m.state_o, S_SWEEP);
        @(negedge clk);
        mode_sweep = 1'b0;
        @(posedge clk);
        #1;
        chk("sweep_exit_state", bus_m.state_o, S_ENTRY_A);
        chk("sweep_exit_raddr", bus_m.raddr_o, 0);
        chk("sweep_exit_display", bus_m.display_o, 0);
        chk("sweep_exit_err", bus_m.err_o, 0);

        // asynchronous reset in the middle of the write burst
        press(4'd1);
        press(K_ADD);
        press(4'd2);
        press(K_ENT);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midwr_we_before", bus_m.we_o, 1);
        chk("midwr_addr_before", bus_m.waddr_o, 7);
        #10;
        rst_n = 1'b0;
        #1;
        chk("midwr_we_m_async", bus_m.we_o, 0);
        chk("midwr_we_s_async", bus_s.we_o, 0);
        chk("midwr_state_async", bus_m.state_o, S_ENTRY_A);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_state", bus_m.state_o, S_ENTRY_A);
        chk("postrst_waddr", bus_m.waddr_o, 0);
        chk("postrst_display", bus_m.display_o, 0);
        chk("postrst_carry", bus_m.carry_o, 0);
        chk("postrst_we", bus_m.we_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
